// File: rtl/timer_pkg.sv
// Shared widths and helpers for the timer counting core.
package timer_pkg;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 2 * DATA_W;
  localparam int DIV_MAX   = 8;
  localparam int DIV_CNT_W = 8;
  localparam int DIV_VAL_W = 4;

  // Terminal divider count for a prescale exponent: 2^eff_div - 1.
  function automatic logic [DIV_CNT_W-1:0] div_period(input logic [DIV_VAL_W-1:0] eff_div);
    logic [DIV_CNT_W:0] pow2;
    pow2 = (DIV_CNT_W + 1)'(1) << eff_div;
    return DIV_CNT_W'(pow2 - (DIV_CNT_W + 1)'(1));
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two prescaler: divides the count rate and restarts its period
// whenever the timer or prescaler is disabled or the exponent changes.
module timer_prescaler
  import timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 timer_en,
  input  logic                 run,
  input  logic                 div_en,
  input  logic [DIV_VAL_W-1:0] div_val,
  output logic                 inc_en
);

  logic [DIV_CNT_W-1:0] div_cnt_reg;
  logic [DIV_CNT_W-1:0] div_cnt_next;
  logic [DIV_VAL_W-1:0] div_val_reg;
  logic [DIV_VAL_W-1:0] eff_div;
  logic                 div_clr;

  always_comb begin
    eff_div      = (div_val > DIV_VAL_W'(DIV_MAX)) ? DIV_VAL_W'(DIV_MAX) : div_val;
    inc_en       = div_en ? (div_cnt_reg == div_period(eff_div)) : 1'b1;
    div_clr      = ~timer_en | ~div_en | (div_val != div_val_reg);
    div_cnt_next = div_cnt_reg;
    // Clear wins over advance; with run low (halt or write) the phase is held.
    if (div_clr) begin
      div_cnt_next = '0;
    end else if (run) begin
      div_cnt_next = inc_en ? '0 : div_cnt_reg + DIV_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_reg <= '0;
      div_val_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_next;
      div_val_reg <= div_val;
    end
  end

endmodule

// File: rtl/timer_counter.sv
// 64-bit timer count with prescaled increment, half-word TDR writes,
// debug halt and clear-on-disable.
module timer_counter
  import timer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 timer_en,
  input  logic                 div_en,
  input  logic [DIV_VAL_W-1:0] div_val,
  input  logic                 dbg_mode,
  input  logic                 halt_req,
  input  logic                 tdr0_wr_sel,
  input  logic                 tdr1_wr_sel,
  input  logic [DATA_W-1:0]    wdata_counter,
  output logic [CNT_W-1:0]     cnt,
  output logic                 cnt_tick
);

  logic             halted;
  logic             wr_any;
  logic             run;
  logic             inc_en;
  logic             timer_en_reg;
  logic             en_fall;
  logic [1:0]       wr_half;
  logic [CNT_W-1:0] wr_merged;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign halted  = dbg_mode & halt_req;
  assign wr_any  = tdr0_wr_sel | tdr1_wr_sel;
  assign run     = timer_en & ~halted & ~wr_any;
  assign en_fall = timer_en_reg & ~timer_en;

  // A simultaneous double write is resolved in favour of the low half.
  assign wr_half[0] = tdr0_wr_sel;
  assign wr_half[1] = tdr1_wr_sel & ~tdr0_wr_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_half
      assign wr_merged[gi*DATA_W +: DATA_W] =
        wr_half[gi] ? wdata_counter : cnt_reg[gi*DATA_W +: DATA_W];
    end
  endgenerate

  timer_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .timer_en (timer_en),
    .run      (run),
    .div_en   (div_en),
    .div_val  (div_val),
    .inc_en   (inc_en)
  );

  assign cnt_tick = ~rst & run & inc_en;

  always_comb begin
    cnt_next = cnt_reg;
    if (en_fall) begin
      cnt_next = '0;
    end else if (wr_any) begin
      cnt_next = wr_merged;
    end else if (cnt_tick) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg      <= '0;
      timer_en_reg <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      timer_en_reg <= timer_en;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: tb/tb_timer_counter.sv
// Directed plus random bench for timer_counter, checked against a
// cycle-level arithmetic reference model of the counting rules.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic        timer_en;
  logic        div_en;
  logic [3:0]  div_val;
  logic        dbg_mode;
  logic        halt_req;
  logic        tdr0_wr_sel;
  logic        tdr1_wr_sel;
  logic [31:0] wdata_counter;
  logic [63:0] cnt;
  logic        cnt_tick;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] m_cnt;
  int          m_phase;
  logic        m_te_prev;
  logic [3:0]  m_dv_prev;
  logic [63:0] saved;

  timer_counter dut (
    .clk           (clk),
    .rst           (rst),
    .timer_en      (timer_en),
    .div_en        (div_en),
    .div_val       (div_val),
    .dbg_mode      (dbg_mode),
    .halt_req      (halt_req),
    .tdr0_wr_sel   (tdr0_wr_sel),
    .tdr1_wr_sel   (tdr1_wr_sel),
    .wdata_counter (wdata_counter),
    .cnt           (cnt),
    .cnt_tick      (cnt_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt     = '0;
    m_phase   = 0;
    m_te_prev = 1'b0;
    m_dv_prev = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic cycle();
    int   eff;
    int   period;
    bit   halted;
    bit   wr;
    bit   inc;
    bit   tick;
    @(negedge clk);
    eff    = (div_val > 4'd8) ? 8 : int'(div_val);
    period = 1 << eff;
    halted = dbg_mode && halt_req;
    wr     = tdr0_wr_sel || tdr1_wr_sel;
    inc    = !div_en || (m_phase == period - 1);
    tick   = !rst && timer_en && !halted && inc && !wr;
    check("cnt", cnt, m_cnt);
    check("cnt_tick", {63'd0, cnt_tick}, {63'd0, tick});
    if (rst) begin
      model_reset();
    end else begin
      if (m_te_prev && !timer_en) m_cnt = '0;
      else if (tdr0_wr_sel)       m_cnt[31:0] = wdata_counter;
      else if (tdr1_wr_sel)       m_cnt[63:32] = wdata_counter;
      else if (tick)              m_cnt = m_cnt + 64'd1;
      if (!timer_en || !div_en || div_val != m_dv_prev) m_phase = 0;
      else if (timer_en && !halted && !wr)             m_phase = inc ? 0 : m_phase + 1;
      m_te_prev = timer_en;
      m_dv_prev = div_val;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; timer_en = 1'b1; div_en = 1'b0; div_val = '0;
    dbg_mode = 1'b0; halt_req = 1'b0; tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b0;
    wdata_counter = '0;
    model_reset();

    // reset holds everything at zero even with timer_en high
    #1;
    check("reset_cnt", cnt, 64'd0);
    check("reset_tick", {63'd0, cnt_tick}, 64'd0);
    repeat (2) cycle();
    rst = 1'b0;
    repeat (10) cycle();
    check("free_run_10", cnt, 64'd10);

    // prescale by 4, then clamped exponent 12 -> 8
    div_en = 1'b1; div_val = 4'd2;
    repeat (16) cycle();
    div_val = 4'd12;
    repeat (600) cycle();

    // wrap via writes, then write coinciding with a tick
    div_en = 1'b0;
    wdata_counter = 32'hFFFF_FFFF; tdr0_wr_sel = 1'b1; cycle();
    tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b1; cycle();
    tdr1_wr_sel = 1'b0; cycle();
    check("wrap_to_zero", cnt, 64'd0);
    wdata_counter = 32'h0000_0005; tdr0_wr_sel = 1'b1; cycle();
    tdr0_wr_sel = 1'b0;
    check("write_drops_tick", cnt, 64'd5);

    // halt with divide-by-4 preserves divider phase
    div_en = 1'b1; div_val = 4'd2;
    repeat (6) cycle();
    dbg_mode = 1'b1; halt_req = 1'b1;
    saved = cnt;
    repeat (20) cycle();
    check("halt_frozen", cnt, saved);
    halt_req = 1'b0;
    repeat (8) cycle();
    dbg_mode = 1'b0; halt_req = 1'b1;
    repeat (10) cycle();
    halt_req = 1'b0;

    // disable clears the count, re-enable starts fresh
    div_en = 1'b0;
    wdata_counter = 32'h0000_1234; tdr0_wr_sel = 1'b1; cycle();
    wdata_counter = 32'h0; tdr0_wr_sel = 1'b0; tdr1_wr_sel = 1'b1; cycle();
    tdr1_wr_sel = 1'b0;
    check("preload_1234", cnt, 64'h1234);
    timer_en = 1'b0; cycle();
    check("disable_clear", cnt, 64'd0);
    timer_en = 1'b1; div_en = 1'b1; div_val = 4'd2;
    repeat (12) cycle();

    // div_val change mid-period restarts the divider
    div_val = 4'd3;
    for (int i = 0; i < 40 && m_phase != 5; i++) cycle();
    check("reach_phase5", 64'(m_phase), 64'd5);
    div_val = 4'd1;
    repeat (6) cycle();

    // asynchronous reset mid-count
    div_en = 1'b0;
    repeat (5) cycle();
    #2 rst = 1'b1;
    #1 check("async_reset", cnt, 64'd0);
    model_reset();
    cycle();
    rst = 1'b0;
    repeat (3) cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      timer_en    = ($urandom_range(0, 19) != 0);
      div_en      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0)
        div_val = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      dbg_mode    = ($urandom_range(0, 1) != 0);
      halt_req    = ($urandom_range(0, 5) == 0);
      tdr0_wr_sel = ($urandom_range(0, 19) == 0);
      tdr1_wr_sel = ($urandom_range(0, 19) == 0);
      wdata_counter = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
